// File: rtl/hls_ram_pkg.sv
// hls_ram_pkg
// Shared types and helpers for the HLS banked RAM slice.
//   state_t  : controller state (CLEAR zero-fills the RAM, SERVE handles requests)
//   addr_w   : word-address width for a given depth (never narrower than 1 bit)
//   BYTES    : number of byte lanes in a data word
package hls_ram_pkg;

  typedef enum logic [0:0] {CLEAR, SERVE} state_t;

  function automatic int addr_w(input int depth);
    int w;
    w = $clog2(depth);
    return (w < 1) ? 1 : w;
  endfunction

  function automatic int BYTES(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/hls_banked_ram_rr_arbiter.sv
// rr_arbiter
// Combinational round-robin arbiter. Picks the lowest requesting index at or
// after ptr, wrapping around N.
//   req       : pending vector
//   ptr       : search start position (held by the caller)
//   grant     : one-hot grant
//   grant_idx : index of the granted requester
//   valid     : high when any requester was granted
module rr_arbiter #(
  parameter int N  = 2,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] grant_idx,
  output logic          valid
);

  // Walk the requesters starting from ptr; the first hit wins.
  always_comb begin
    int k;
    k         = 0;
    grant     = '0;
    grant_idx = '0;
    valid     = 1'b0;
    for (int i = 0; i < N; i++) begin
      k = int'(ptr) + i;
      if (k >= N) k = k - N;
      if (!valid && req[k]) begin
        valid     = 1'b1;
        grant[k]  = 1'b1;
        grant_idx = PW'(k);
      end
    end
  end

endmodule

// File: rtl/hls_banked_ram.sv
// hls_banked_ram
// Multi-channel block RAM for HLS datapaths. Each channel uses a toggle
// request/acknowledge handshake; one access per cycle is granted round-robin.
//   clk, reset : clock and synchronous active-high reset
//   u_en       : per-channel request toggle
//   wr_en      : per-channel write (1) / read (0)
//   addr       : per-channel word address, packed ADDR_W per channel
//   d_in       : per-channel write data, packed DATA_W per channel
//   be         : per-channel byte-lane write enables
//   en         : per-channel acknowledge toggle
//   d_out      : per-channel read data
//   ready      : high while requests are being served
//   oob_err    : sticky flag, set by any access with addr >= DEPTH
// Build option: HLS_RAM_CLEAR_ON_RESET_EN adds a CLEAR state that zero-fills
// the RAM one word per cycle after reset before any request is served.
module hls_banked_ram
  import hls_ram_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 16,
  parameter int CHANNELS = 2,
  parameter int ADDR_W   = addr_w(DEPTH)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [CHANNELS-1:0]            u_en,
  input  logic [CHANNELS-1:0]            wr_en,
  input  logic [CHANNELS*ADDR_W-1:0]     addr,
  input  logic [CHANNELS*DATA_W-1:0]     d_in,
  input  logic [CHANNELS*DATA_W/8-1:0]   be,
  output logic [CHANNELS-1:0]            en,
  output logic [CHANNELS*DATA_W-1:0]     d_out,
  output logic                           ready,
  output logic                           oob_err
);

  localparam int NB = BYTES(DATA_W);
  localparam int PW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  state_t              state;
  logic [CHANNELS-1:0] seen;
  logic [CHANNELS-1:0] pending;
  logic [CHANNELS-1:0] grant;
  logic [PW-1:0]       ptr;
  logic [PW-1:0]       g_idx;
  logic                g_valid;
  logic                go;
  logic                g_wr;
  logic                g_in_range;
  logic [ADDR_W-1:0]   g_addr;
  logic [DATA_W-1:0]   g_data;
  logic [NB-1:0]       g_be;
  logic                clr_we;
  logic [ADDR_W-1:0]   clr_addr;

  (* ram_style = "block" *) logic [DATA_W-1:0] mem [DEPTH];

  assign pending = u_en ^ seen;

  rr_arbiter #(.N(CHANNELS), .PW(PW)) u_arb (
    .req       (pending),
    .ptr       (ptr),
    .grant     (grant),
    .grant_idx (g_idx),
    .valid     (g_valid)
  );

  assign go = g_valid && (state == SERVE);

  // Route the granted channel's request fields to the single RAM port.
  always_comb begin
    g_wr       = wr_en[g_idx];
    g_addr     = addr[g_idx*ADDR_W +: ADDR_W];
    g_data     = d_in[g_idx*DATA_W +: DATA_W];
    g_be       = be[g_idx*NB +: NB];
    g_in_range = (int'(g_addr) < DEPTH);
  end

`ifdef HLS_RAM_CLEAR_ON_RESET_EN
  logic [ADDR_W-1:0] clr_idx;

  // CLEAR walks clr_idx over every word, then hands over to SERVE for good.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= CLEAR;
      clr_idx <= '0;
      ready   <= 1'b0;
    end else begin
      case (state)
        CLEAR: begin
          if (clr_idx == ADDR_W'(DEPTH - 1)) begin
            state <= SERVE;
            ready <= 1'b1;
          end else begin
            clr_idx <= clr_idx + 1'b1;
          end
        end
        SERVE: ready <= 1'b1;
      endcase
    end
  end

  assign clr_we   = (state == CLEAR) && !reset;
  assign clr_addr = clr_idx;
`else
  assign state    = SERVE;
  assign ready    = 1'b1;
  assign clr_we   = 1'b0;
  assign clr_addr = '0;
`endif

  // Sole writer of the RAM array; out-of-range writes and reset cycles leave
  // the contents untouched.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_addr] <= '0;
    end else if (go && g_wr && g_in_range && !reset) begin
      for (int b = 0; b < NB; b++) begin
        if (g_be[b]) mem[g_addr][b*8 +: 8] <= g_data[b*8 +: 8];
      end
    end
  end

  // Handshake bookkeeping and read data. A grant copies the sampled u_en bit
  // into seen, so a toggle landing on the grant edge stays pending.
  always_ff @(posedge clk) begin
    if (reset) begin
      seen    <= '0;
      en      <= '0;
      ptr     <= '0;
      oob_err <= 1'b0;
      d_out   <= '0;
    end else if (go) begin
      seen <= (seen & ~grant) | (u_en & grant);
      en   <= en ^ grant;
      ptr  <= (int'(g_idx) == CHANNELS - 1) ? '0 : g_idx + 1'b1;
      if (!g_in_range) oob_err <= 1'b1;
      if (!g_wr) d_out[g_idx*DATA_W +: DATA_W] <= g_in_range ? mem[g_addr] : '0;
    end
  end

endmodule

// File: doc/hls_banked_ram.md
# hls_banked_ram

Parametrised multi-channel block RAM for HLS-generated datapaths, serving CHANNELS independent requesters over toggle-based request/acknowledge handshakes. It generalises the single-requester stack RAM interface to configurable data width, depth and channel count, and adds round-robin arbitration, byte-lane writes and out-of-range detection. It sits between the generated FSM-with-datapath modules and one single-port block RAM inferred with `ram_style = "block"`.

## Interface
- DATA_W, 32, data word width; must be a multiple of 8.
- DEPTH, 16, number of words; need not be a power of two.
- CHANNELS, 2, number of requester channels, 1..8.
- ADDR_W, $clog2(DEPTH) (minimum 1), word address width.
- clk  input  1  single clock; all logic on posedge.
- reset  input  1  synchronous, active-high.
- u_en  input  CHANNELS  per-channel request toggle.
- wr_en  input  CHANNELS  per-channel write (1) / read (0) select.
- addr  input  CHANNELS*ADDR_W  per-channel word address, channel c at [c*ADDR_W +: ADDR_W].
- d_in  input  CHANNELS*DATA_W  per-channel write data.
- be  input  CHANNELS*DATA_W/8  per-channel byte-lane write enables.
- en  output  CHANNELS  per-channel acknowledge toggle.
- d_out  output  CHANNELS*DATA_W  per-channel read data.
- ready  output  1  high when requests are being served.
- oob_err  output  1  sticky out-of-range flag.

## Operation
- Channel c is pending when u_en[c] != seen[c]. seen[c] is internal and reset to 0.
- One RAM access per cycle. rr_arbiter grants the lowest pending channel at or after pointer ptr, wrapping. After a grant to c, ptr <= (c+1) mod CHANNELS.
- Granted read: d_out[c] <= ram[addr[c]].
- Granted write: for each byte lane b with be[c][b]=1, lane b of ram[addr[c]] <= lane b of d_in[c]. d_out[c] is unchanged.
- Every grant performs seen[c] <= u_en[c] and en[c] <= ~en[c] on the same edge.
- Inputs are sampled on the grant edge. A requester holds wr_en, addr, d_in and be stable until it sees en[c] toggle.
- Out-of-range (addr >= DEPTH): a write is dropped, a read returns 0, oob_err <= 1. The request is still acknowledged normally.
- Accesses from different channels take effect strictly in grant order. A read granted after a write to the same word returns the new data.
- FSM states (from hls_ram_pkg): CLEAR, SERVE.
  - Reset enters CLEAR when the macro is defined, otherwise SERVE.
  - CLEAR writes 0 to word clr_idx, one word per cycle, from 0 to DEPTH-1, then moves to SERVE.
  - ready is 1 only in SERVE. No grants occur in CLEAR; pending requests stay pending.
- Reset values: en=0, d_out=0, oob_err=0, ptr=0, seen=0, clr_idx=0. ready=0 with the macro, ready=1 without it.
- Reset does not modify RAM contents (except through CLEAR).
- Reset mid-operation abandons all in-flight requests. A u_en[c] that is 1 when reset releases is a new pending request.

## Timing
- Latency: a toggle registered at edge E is granted at edge E+1 if uncontended. en[c] and d_out[c] are valid after edge E+1.
- Worst-case wait with all channels pending: CHANNELS cycles.
- A channel toggling again on the edge of its own grant registers a new pending request. That request is eligible one cycle later, behind the other pending channels.
- CLEAR lasts exactly DEPTH cycles after reset deasserts.
- Maximum throughput: one access per cycle in aggregate, and one access per CHANNELS cycles per channel under full contention.

## Configuration
- HLS_RAM_CLEAR_ON_RESET_EN defined: the CLEAR state, clr_idx counter and zero-fill are compiled in. ready stays low for DEPTH cycles after reset.
- Not defined: there is no CLEAR state. The FSM is fixed in SERVE, ready=1 out of reset, and RAM contents are retained/undefined.

## Structure
- Package hls_ram_pkg holds:
  - state enum {CLEAR, SERVE};
  - localparam function addr_w(depth);
  - byte-lane count helper BYTES(DATA_W).
- Sub-module rr_arbiter (parameter N) takes the pending vector and ptr and returns a one-hot grant and the grant index. It is purely combinational. The pointer register lives in hls_banked_ram.
- The RAM array is a single `ram_style = "block"` array written in one always block, so it infers as block RAM.

## Test plan
- Clear: macro on, DEPTH=16. Assert reset 1 cycle. ready=0 for 16 cycles, then 1. Read all 16 words: each returns 0x00000000.
- Single write/read, ch0: write addr 3, d_in 0xDEADBEEF, be 4'hF; then read addr 3. en[0] toggles 1 cycle after each request, and d_out[0]=0xDEADBEEF.
- Byte lanes: word 5 holds 0x11223344; write d_in 0xAABBCCDD with be 4'b0101, then read. Result is 0x11BB33DD.
- Contention: CHANNELS=3, all toggle on the same edge, ch2 writes 0x7 to addr 0, ch0/ch1 read addr 0. Grants go ch0, ch1, ch2 on consecutive cycles. ch0/ch1 see the old value, then a re-read shows 0x7. ptr=0 afterwards.
- Out-of-range: DEPTH=10, write 0x55 to addr 12. The request is acknowledged, oob_err=1 stays set, words 0..9 are unchanged, and a read of addr 12 returns 0.
- Reset mid-operation: ch1 toggles u_en, and reset asserts on the same edge. After release, en=0, d_out=0, and oob_err is cleared. u_en[1]=1 is then served as a new request.
